// File: rtl/vx_data_array_pkg.sv
// Shared definitions for the cache data array: FSM state encoding and the
// width helper used to size way, line and word-select fields.
package vx_data_array_pkg;

    // INIT sweeps the array to zero after reset; READY serves requests.
    typedef enum logic {
        ST_INIT  = 1'b0,
        ST_READY = 1'b1
    } state_e;

    localparam int BYTE_BITS = 8;

    // Index width for n entries, never narrower than one bit.
    function automatic int clog2_min1(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/vx_data_array_sp_ram.sv
// Per-way line storage: byte-masked synchronous write and a registered,
// read-first read port whose output holds until the next read enable.
module vx_data_array_sp_ram
    import vx_data_array_pkg::*;
#(
    parameter int DATAW   = 512,
    parameter int SIZE    = 64,
    parameter int BYTEENW = 64,
    localparam int ADDRW  = clog2_min1(SIZE)
) (
    input  logic               clk,
    input  logic               we,
    input  logic [BYTEENW-1:0] byteen,
    input  logic [ADDRW-1:0]   waddr,
    input  logic [DATAW-1:0]   wdata,
    input  logic               re,
    input  logic [ADDRW-1:0]   raddr,
    output logic [DATAW-1:0]   rdata
);

    localparam int LANE_W = DATAW / BYTEENW;

    logic [DATAW-1:0] mem_q [SIZE];
    logic [DATAW-1:0] rdata_q;

    // Byte-lane masked write into the addressed line
    always_ff @(posedge clk) begin
        if (we) begin
            for (int b = 0; b < BYTEENW; b++) begin
                if (byteen[b]) begin
                    mem_q[waddr][b*LANE_W +: LANE_W] <= wdata[b*LANE_W +: LANE_W];
                end
            end
        end
    end

    // Registered read; returns the pre-write value on a same-edge write
    always_ff @(posedge clk) begin
        if (re) begin
            rdata_q <= mem_q[raddr];
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/vx_data_array.sv
// Cache data array: NUM_WAYS ways of LINES_PER_WAY lines, zeroed by an INIT
// sweep after reset, with a valid/ready read channel and an unthrottled
// fill/word write port.
// Optional feature macro: DATA_ARRAY_BYPASS_EN -- when defined, a read and a
// write to the same way/line in one cycle are both accepted and the response
// carries the written bytes merged over the stored line; when undefined the
// read is held off (rd_ready=0) for that cycle instead.
module vx_data_array
    import vx_data_array_pkg::*;
#(
    parameter int NUM_WAYS      = 4,
    parameter int LINES_PER_WAY = 64,
    parameter int LINE_SIZE     = 64,
    parameter int WORD_SIZE     = 4,
    parameter int WRITE_ENABLE  = 1,
    localparam int WAY_W  = clog2_min1(NUM_WAYS),
    localparam int LINE_W = clog2_min1(LINES_PER_WAY),
    localparam int WORDS  = LINE_SIZE / WORD_SIZE,
    localparam int WSEL_W = clog2_min1(WORDS),
    localparam int DATA_W = LINE_SIZE * BYTE_BITS
) (
    input  logic                 clk,
    input  logic                 reset,
    output logic                 init_done,
    input  logic                 rd_valid,
    output logic                 rd_ready,
    input  logic [WAY_W-1:0]     rd_way,
    input  logic [LINE_W-1:0]    rd_line,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [DATA_W-1:0]    rsp_data,
    input  logic                 wr_en,
    input  logic                 wr_fill,
    input  logic [WAY_W-1:0]     wr_way,
    input  logic [LINE_W-1:0]    wr_line,
    input  logic [WSEL_W-1:0]    wr_wsel,
    input  logic [WORD_SIZE-1:0] wr_byteen,
    input  logic [DATA_W-1:0]    wr_data
);

    localparam int WORD_BITS = WORD_SIZE * BYTE_BITS;

    state_e              state_q, state_d;
    logic [LINE_W-1:0]   sweep_q, sweep_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic [WAY_W-1:0]    rsp_way_q;

    logic                in_ready;
    logic                same_target;
    logic                wr_act;
    logic                rd_fire;

    logic [LINE_SIZE-1:0] wr_ben_line;
    logic [DATA_W-1:0]    wr_data_line;

    logic [NUM_WAYS-1:0]  ram_we;
    logic [NUM_WAYS-1:0]  ram_re;
    logic [LINE_W-1:0]    ram_waddr;
    logic [DATA_W-1:0]    ram_wdata;
    logic [LINE_SIZE-1:0] ram_ben;
    logic [DATA_W-1:0]    ram_rdata [NUM_WAYS];

    assign in_ready    = (state_q == ST_READY);
    assign same_target = (wr_way == rd_way) && (wr_line == rd_line);
    // Word writes are dropped entirely when partial writes are disabled.
    assign wr_act      = in_ready && wr_en && (wr_fill || (WRITE_ENABLE != 0));

`ifdef DATA_ARRAY_BYPASS_EN
    assign rd_ready = in_ready && (!rsp_valid_q || rsp_ready);
`else
    // A read colliding with any write to its line waits a cycle so it sees
    // the written data straight from the RAM.
    assign rd_ready = in_ready && (!rsp_valid_q || rsp_ready) && !(wr_en && same_target);
`endif

    assign rd_fire   = rd_valid && rd_ready;
    assign init_done = in_ready;
    assign rsp_valid = rsp_valid_q;

    // Shape a write into full-line data plus per-byte enables; word data is
    // taken from the low word of wr_data and replicated into every word slot
    always_comb begin
        wr_ben_line  = '0;
        wr_data_line = wr_data;
        if (wr_fill) begin
            wr_ben_line = '1;
        end else begin
            for (int w = 0; w < WORDS; w++) begin
                wr_data_line[w*WORD_BITS +: WORD_BITS] = wr_data[WORD_BITS-1:0];
                if (wr_wsel == WSEL_W'(w)) begin
                    wr_ben_line[w*WORD_SIZE +: WORD_SIZE] = wr_byteen;
                end
            end
        end
    end

    // RAM port steering: the INIT sweep zeroes one line in every way,
    // READY routes the user write to its way; reads enable only on accept
    always_comb begin
        ram_waddr = wr_line;
        ram_wdata = wr_data_line;
        ram_ben   = wr_ben_line;
        ram_we    = '0;
        ram_re    = '0;
        if (state_q == ST_INIT) begin
            ram_waddr = sweep_q;
            ram_wdata = '0;
            ram_ben   = '1;
            ram_we    = '1;
        end else if (wr_act) begin
            ram_we[wr_way] = 1'b1;
        end
        if (rd_fire) begin
            ram_re[rd_way] = 1'b1;
        end
    end

    for (genvar w = 0; w < NUM_WAYS; w++) begin : g_way
        vx_data_array_sp_ram #(
            .DATAW   (DATA_W),
            .SIZE    (LINES_PER_WAY),
            .BYTEENW (LINE_SIZE)
        ) u_ram (
            .clk    (clk),
            .we     (ram_we[w]),
            .byteen (ram_ben),
            .waddr  (ram_waddr),
            .wdata  (ram_wdata),
            .re     (ram_re[w]),
            .raddr  (rd_line),
            .rdata  (ram_rdata[w])
        );
    end

    // Control registers: FSM state, sweep count and response valid
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= ST_INIT;
            sweep_q     <= '0;
            rsp_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            sweep_q     <= sweep_d;
            rsp_valid_q <= rsp_valid_d;
        end
    end

    // Next state: one swept line per INIT cycle, then READY; response valid
    // rises on accept and falls when the consumer takes it
    always_comb begin
        state_d     = state_q;
        sweep_d     = sweep_q;
        rsp_valid_d = rsp_valid_q;
        case (state_q)
            ST_INIT: begin
                sweep_d = sweep_q + 1'b1;
                if (sweep_q == LINE_W'(LINES_PER_WAY - 1)) begin
                    state_d = ST_READY;
                end
            end
            ST_READY: state_d = ST_READY;
            default:  state_d = ST_INIT;
        endcase
        if (rd_fire) begin
            rsp_valid_d = 1'b1;
        end else if (rsp_ready) begin
            rsp_valid_d = 1'b0;
        end
    end

    // Remember which way owns the outstanding response
    always_ff @(posedge clk) begin
        if (rd_fire) begin
            rsp_way_q <= rd_way;
        end
    end

`ifdef DATA_ARRAY_BYPASS_EN
    logic [DATA_W-1:0] wr_bit_mask;
    logic [DATA_W-1:0] byp_mask_q;
    logic [DATA_W-1:0] byp_data_q;

    // Expand byte enables to a bit mask for the bypass merge
    always_comb begin
        wr_bit_mask = '0;
        for (int b = 0; b < LINE_SIZE; b++) begin
            wr_bit_mask[b*BYTE_BITS +: BYTE_BITS] = {BYTE_BITS{wr_ben_line[b]}};
        end
    end

    // Capture bytes a same-cycle write lays over the line being read; the
    // RAM returns the pre-write line, so these are merged on the way out
    always_ff @(posedge clk) begin
        if (rd_fire) begin
            byp_mask_q <= (wr_act && same_target) ? wr_bit_mask : '0;
            byp_data_q <= wr_data_line;
        end
    end

    assign rsp_data = (ram_rdata[rsp_way_q] & ~byp_mask_q) | (byp_data_q & byp_mask_q);
`else
    assign rsp_data = ram_rdata[rsp_way_q];
`endif

endmodule

// File: tb/tb_vx_data_array.sv
// Bench for vx_data_array: two instances (WRITE_ENABLE=1 and 0) share the
// stimulus and are compared every cycle against a line-level reference model.
module tb_vx_data_array;

    localparam int WAYS  = 4;
    localparam int LINES = 64;
    localparam int LSZ   = 64;
    localparam int WSZ   = 4;
    localparam int LB    = LSZ * 8;
`ifdef DATA_ARRAY_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic          rd_valid;
    logic [1:0]    rd_way;
    logic [5:0]    rd_line;
    logic          rsp_ready;
    logic          wr_en;
    logic          wr_fill;
    logic [1:0]    wr_way;
    logic [5:0]    wr_line;
    logic [3:0]    wr_wsel;
    logic [3:0]    wr_byteen;
    logic [LB-1:0] wr_data;

    logic          init_done1, rd_ready1, rsp_valid1;
    logic [LB-1:0] rsp_data1;
    logic          init_done0, rd_ready0, rsp_valid0;
    logic [LB-1:0] rsp_data0;

    int errs   = 0;
    int checks = 0;

    // reference model state
    logic [LB-1:0] m1 [WAYS][LINES];
    logic [LB-1:0] m0 [WAYS][LINES];
    int            init_cnt;
    bit            exp_valid;
    logic [LB-1:0] exp_d1, exp_d0;
    bit            last_fire;

    always #5 clk = ~clk;

    vx_data_array #(
        .NUM_WAYS(WAYS), .LINES_PER_WAY(LINES), .LINE_SIZE(LSZ),
        .WORD_SIZE(WSZ), .WRITE_ENABLE(1)
    ) u_dut (
        .clk(clk), .reset(reset), .init_done(init_done1),
        .rd_valid(rd_valid), .rd_ready(rd_ready1), .rd_way(rd_way), .rd_line(rd_line),
        .rsp_valid(rsp_valid1), .rsp_ready(rsp_ready), .rsp_data(rsp_data1),
        .wr_en(wr_en), .wr_fill(wr_fill), .wr_way(wr_way), .wr_line(wr_line),
        .wr_wsel(wr_wsel), .wr_byteen(wr_byteen), .wr_data(wr_data)
    );

    vx_data_array #(
        .NUM_WAYS(WAYS), .LINES_PER_WAY(LINES), .LINE_SIZE(LSZ),
        .WORD_SIZE(WSZ), .WRITE_ENABLE(0)
    ) u_dut_we0 (
        .clk(clk), .reset(reset), .init_done(init_done0),
        .rd_valid(rd_valid), .rd_ready(rd_ready0), .rd_way(rd_way), .rd_line(rd_line),
        .rsp_valid(rsp_valid0), .rsp_ready(rsp_ready), .rsp_data(rsp_data0),
        .wr_en(wr_en), .wr_fill(wr_fill), .wr_way(wr_way), .wr_line(wr_line),
        .wr_wsel(wr_wsel), .wr_byteen(wr_byteen), .wr_data(wr_data)
    );

    task automatic chk(input string tag, input logic [LB-1:0] got, input logic [LB-1:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [LB-1:0] rand_line();
        logic [LB-1:0] v;
        for (int i = 0; i < LB / 32; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    task automatic idle();
        rd_valid = 0; rd_way = 0; rd_line = 0; rsp_ready = 1;
        wr_en = 0; wr_fill = 0; wr_way = 0; wr_line = 0;
        wr_wsel = 0; wr_byteen = 0; wr_data = '0;
    endtask

    // One clock: compare outputs mid-cycle, advance the model across the edge.
    task automatic cycle();
        bit ready, hit, exp_rdy;
        @(negedge clk);
        ready   = (init_cnt >= LINES);
        hit     = wr_en && (wr_way == rd_way) && (wr_line == rd_line);
        exp_rdy = ready && (!exp_valid || rsp_ready) && (BYP || !hit);
        chk("init_done", init_done1, ready);
        chk("init_done_we0", init_done0, ready);
        chk("rd_ready", rd_ready1, exp_rdy);
        chk("rd_ready_we0", rd_ready0, exp_rdy);
        chk("rsp_valid", rsp_valid1, exp_valid);
        chk("rsp_valid_we0", rsp_valid0, exp_valid);
        if (exp_valid) begin
            chk("rsp_data", rsp_data1, exp_d1);
            chk("rsp_data_we0", rsp_data0, exp_d0);
        end
        last_fire = 0;
        if (!reset) begin
            init_cnt  = 0;
            exp_valid = 0;
        end else if (!ready) begin
            init_cnt++;
            if (init_cnt == LINES) begin
                for (int w = 0; w < WAYS; w++)
                    for (int l = 0; l < LINES; l++) begin
                        m1[w][l] = '0;
                        m0[w][l] = '0;
                    end
            end
        end else begin
            if (wr_en) begin
                if (wr_fill) begin
                    m1[wr_way][wr_line] = wr_data;
                    m0[wr_way][wr_line] = wr_data;
                end else begin
                    for (int b = 0; b < WSZ; b++)
                        if (wr_byteen[b])
                            m1[wr_way][wr_line][(int'(wr_wsel)*WSZ + b)*8 +: 8] = wr_data[b*8 +: 8];
                end
            end
            if (exp_valid && rsp_ready) exp_valid = 0;
            if (rd_valid && exp_rdy) begin
                exp_valid = 1;
                exp_d1    = m1[rd_way][rd_line];
                exp_d0    = m0[rd_way][rd_line];
                last_fire = 1;
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic wait_init(input string tag);
        int n = 0;
        while (init_done1 !== 1'b1 && n < 200) begin
            cycle();
            n++;
        end
        chk(tag, n, LINES);
    endtask

    task automatic do_read(input int w, input int l);
        int n = 0;
        rd_valid = 1; rd_way = 2'(w); rd_line = 6'(l);
        do begin
            cycle();
            n++;
        end while (!last_fire && n < 50);
        chk("rd_accept", last_fire, 1);
        rd_valid = 0;
    endtask

    task automatic do_write(input bit fill, input int w, input int l, input int wsel,
                            input logic [3:0] ben, input logic [LB-1:0] d);
        wr_en = 1; wr_fill = fill; wr_way = 2'(w); wr_line = 6'(l);
        wr_wsel = 4'(wsel); wr_byteen = ben; wr_data = d;
        cycle();
        wr_en = 0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [LB-1:0] pat_a, pat_b, wdat, expm;
        idle();
        reset = 0;
        repeat (2) @(posedge clk);
        #1;
        init_cnt = 0; exp_valid = 0; last_fire = 0;
        cycle();
        reset = 1;
        wait_init("init_len");

        // cleared array: last line of last way reads zero
        do_read(3, 63);
        chk("w3l63_zero", rsp_data1, '0);
        cycle();

        // fill then read back
        pat_a = rand_line();
        do_write(1, 1, 5, 0, 4'h0, pat_a);
        do_read(1, 5);
        chk("fill_A", rsp_data1, pat_a);
        cycle();

        // partial word write: only bytes 8 and 10 change
        wdat = rand_line();
        wdat[31:0] = 32'hAABBCCDD;
        do_write(0, 1, 5, 2, 4'b0101, wdat);
        do_read(1, 5);
        chk("word_b8", rsp_data1[71:64], 8'hDD);
        chk("word_b9", rsp_data1[79:72], pat_a[79:72]);
        chk("word_b10", rsp_data1[87:80], 8'hBB);
        chk("word_b11", rsp_data1[95:88], pat_a[95:88]);
        chk("we0_unchanged", rsp_data0, pat_a);
        cycle();

        // stalled response: no new reads accepted, data held
        rsp_ready = 0;
        do_read(1, 5);
        rd_valid = 1; rd_way = 2; rd_line = 9;
        for (int i = 0; i < 5; i++) begin
            chk("stall_rdy", rd_ready1, 0);
            cycle();
        end
        rd_valid = 0;
        rsp_ready = 1;
        cycle();

        // same-cycle write and read, way 0 line 7
        pat_b = rand_line();
        do_write(1, 0, 7, 0, 4'h0, pat_b);
        wdat = rand_line();
        expm = pat_b;
        expm[31:0] = wdat[31:0];
        wr_en = 1; wr_fill = 0; wr_way = 0; wr_line = 7; wr_wsel = 0;
        wr_byteen = 4'hF; wr_data = wdat;
        rd_valid = 1; rd_way = 0; rd_line = 7;
        cycle();
        chk("same_cyc_fire", last_fire, BYP);
        wr_en = 0;
        if (!last_fire) do_read(0, 7);
        rd_valid = 0;
        chk("same_cyc_data", rsp_data1, expm);
        cycle();

        // reset mid-sweep at count 20: sweep restarts in full
        reset = 0; cycle(); reset = 1;
        repeat (20) cycle();
        reset = 0; cycle(); reset = 1;
        wait_init("init_restart");

        // reset while a response is stalled
        rsp_ready = 0;
        do_read(0, 7);
        cycle();
        reset = 0;
        cycle();
        chk("rst_drops_rsp", rsp_valid1, 0);
        reset = 1;
        rsp_ready = 1;
        wait_init("init_after_stall");

        // randomized traffic over a small address window
        for (int i = 0; i < 1500; i++) begin
            reset     = ($urandom_range(0, 399) != 0);
            rd_valid  = $urandom_range(0, 1);
            rd_way    = 2'($urandom_range(0, 3));
            rd_line   = 6'($urandom_range(0, 7));
            rsp_ready = ($urandom_range(0, 9) < 7);
            wr_en     = ($urandom_range(0, 9) < 4);
            wr_fill   = $urandom_range(0, 1);
            wr_way    = 2'($urandom_range(0, 3));
            wr_line   = 6'($urandom_range(0, 7));
            wr_wsel   = 4'($urandom_range(0, 15));
            wr_byteen = 4'($urandom_range(0, 15));
            wr_data   = rand_line();
            cycle();
        end
        idle();
        reset = 1;
        repeat (3) cycle();

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
